// File: rtl/npc_pkg.sv
// Shared widths and the write-source tag for the writeback stage.
package npc_pkg;

  localparam int unsigned NPC_ADDR_WIDTH = 5;
  localparam int unsigned NPC_DATA_WIDTH = 32;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry holding register for a load return that lost arbitration to the ALU.
module wb_skid_buf
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NPC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = NPC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] push_rd_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  full_q, full_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Push after pop so a same-cycle pop/push leaves the new entry resident.
  always_comb begin
    full_d = full_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push_i) begin
      full_d = 1'b1;
      rd_d   = push_rd_i;
      data_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign rd_o   = rd_q;
  assign data_o = data_q;

endmodule

// File: rtl/writeback_stage.sv
// Merges ALU and load-return streams onto the register file write port and
// tracks outstanding loads to stall issue on RAW/WAW hazards.
module writeback_stage
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NPC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = NPC_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        iss_valid,
  input  logic                        iss_is_load,
  input  logic [ADDR_WIDTH-1:0]       iss_rs1,
  input  logic [ADDR_WIDTH-1:0]       iss_rs2,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  output logic                        iss_stall,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_WIDTH-1:0]       ld_rd,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_rd,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic [(2**ADDR_WIDTH)-1:0]  busy_mask,
  output logic                        err_stray_load
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic                  skid_full;
  logic [ADDR_WIDTH-1:0] skid_rd;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_push, skid_pop;

  logic                  ld_fire, iss_fire;
  logic                  win_valid;
  wb_src_e               win_src;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  wb_src_e               src_q, src_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  err_q, err_d;

  wb_skid_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (skid_push),
    .pop_i       (skid_pop),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .full_o      (skid_full),
    .rd_o        (skid_rd),
    .data_o      (skid_data)
  );

  assign ld_ready  = !skid_full;
  assign ld_fire   = ld_valid && ld_ready;
  assign iss_stall = iss_valid &&
                     (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd] || skid_full);
  assign iss_fire  = iss_valid && !iss_stall;

  // Priority: ALU, then skid entry, then a freshly accepted load.
  always_comb begin
    win_valid = 1'b0;
    win_src   = WB_ALU;
    win_rd    = '0;
    win_data  = '0;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
      skid_push = ld_fire;
    end else if (skid_full) begin
      win_valid = 1'b1;
      win_src   = WB_LOAD;
      win_rd    = skid_rd;
      win_data  = skid_data;
      skid_pop  = 1'b1;
    end else if (ld_fire) begin
      win_valid = 1'b1;
      win_src   = WB_LOAD;
      win_rd    = ld_rd;
      win_data  = ld_data;
    end
  end

  always_comb begin
    rf_wen_d   = win_valid && (win_rd != '0);
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    src_d      = src_q;
    if (win_valid) begin
      rf_rd_d    = win_rd;
      rf_wdata_d = win_data;
      src_d      = win_src;
    end
  end

  // Clear lands on the register-file commit edge; a same-edge set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q && (src_q == WB_LOAD)) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (iss_fire && iss_is_load && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (ld_fire && (ld_rd != '0) && !busy_q[ld_rd]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      src_q      <= WB_ALU;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rf_wen         = rf_wen_q;
  assign rf_rd          = rf_rd_q;
  assign rf_wdata       = rf_wdata_q;
  assign busy_mask      = busy_q;
  assign err_stray_load = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: expected register-file writes are queued as stimulus is driven.
module tb_writeback_stage;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid, iss_is_load;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
  logic            iss_stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            ld_valid, ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [DW-1:0]   ld_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] busy_mask;
  logic            err_stray_load;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  writeback_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iss_valid      (iss_valid),
    .iss_is_load    (iss_is_load),
    .iss_rs1        (iss_rs1),
    .iss_rs2        (iss_rs2),
    .iss_rd         (iss_rd),
    .iss_stall      (iss_stall),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .rf_wen         (rf_wen),
    .rf_rd          (rf_rd),
    .rf_wdata       (rf_wdata),
    .busy_mask      (busy_mask),
    .err_stray_load (err_stray_load)
  );

  // Every observed register-file write must match the oldest queued expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_wen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got rd=%0d data=%h, expected no write", rf_rd, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if (rf_rd !== e.rd || rf_wdata !== e.data) begin
            errors++;
            $display("FAIL sb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                     rf_rd, rf_wdata, e.rd, e.data);
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_is_load = 1'b0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0 || rf_rd !== '0 || rf_wdata !== '0 || busy_mask !== '0 ||
        err_stray_load !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: wen=%b rd=%0d wdata=%h busy=%h err=%b ld_ready=%b, expected 0/0/0/0/0/1",
               rf_wen, rf_rd, rf_wdata, busy_mask, err_stray_load, ld_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd3, 32'hDEADBEEF});
    @(negedge clk);
    alu_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_latency: wen=%b rd=%0d data=%h, expected 1/3/deadbeef", rf_wen, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_load_hazard();
    @(negedge clk);
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
    #1;
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL hz_first_issue: stall=%b, expected 0", iss_stall);
    end
    @(negedge clk);
    checks++;
    if (busy_mask[5] !== 1'b1) begin
      errors++;
      $display("FAIL hz_busy_set: busy[5]=%b, expected 1", busy_mask[5]);
    end
    iss_is_load = 1'b0; iss_rd = 5'd6; iss_rs1 = 5'd5; iss_rs2 = 5'd0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (iss_stall !== 1'b1) begin
        errors++;
        $display("FAIL hz_stall_wait%0d: stall=%b, expected 1", i, iss_stall);
      end
      @(negedge clk);
    end
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h0000_1234;
    exp_q.push_back({5'd5, 32'h0000_1234});
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    checks++;
    if (iss_stall !== 1'b1 || busy_mask[5] !== 1'b1) begin
      errors++;
      $display("FAIL hz_commit_edge: stall=%b busy5=%b, expected 1/1", iss_stall, busy_mask[5]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (iss_stall !== 1'b0 || busy_mask[5] !== 1'b0) begin
      errors++;
      $display("FAIL hz_release: stall=%b busy5=%b, expected 0/0", iss_stall, busy_mask[5]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_alu_load_collision();
    @(negedge clk);
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd5; iss_rs1 = '0; iss_rs2 = '0;
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA5A5_0002;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h5A5A_0005;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL col_ready_before: ld_ready=%b, expected 1", ld_ready);
    end
    exp_q.push_back({5'd2, 32'hA5A5_0002});
    exp_q.push_back({5'd5, 32'h5A5A_0005});
    @(negedge clk);
    idle_inputs();
    checks++;
    if (ld_ready !== 1'b0 || rf_rd !== 5'd2) begin
      errors++;
      $display("FAIL col_alu_first: ld_ready=%b rd=%0d, expected 0/2", ld_ready, rf_rd);
    end
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd5) begin
      errors++;
      $display("FAIL col_skid_drain: ld_ready=%b wen=%b rd=%0d, expected 1/1/5", ld_ready, rf_wen, rf_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL x0_alu: wen=%b, expected 0", rf_wen);
    end
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1111_0000;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ld_ready: ld_ready=%b, expected 1", ld_ready);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || err_stray_load !== 1'b0) begin
      errors++;
      $display("FAIL x0_load: wen=%b err=%b, expected 0/0", rf_wen, err_stray_load);
    end
  endtask

  task automatic test_stray_load();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0707_0707;
    exp_q.push_back({5'd7, 32'h0707_0707});
    @(negedge clk);
    ld_valid = 1'b0;
    checks++;
    if (err_stray_load !== 1'b1) begin
      errors++;
      $display("FAIL stray_set: err=%b, expected 1", err_stray_load);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_stray_load !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky: err=%b, expected 1", err_stray_load);
    end
  endtask

  task automatic test_reset_midop();
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd5; iss_rs1 = '0; iss_rs2 = '0;
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hCAFE_0002;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hBEEF_0005;
    @(posedge clk);
    #1;
    checks++;
    if (ld_ready !== 1'b0 || rf_wen !== 1'b1 || busy_mask[5] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: ld_ready=%b wen=%b busy5=%b, expected 0/1/1", ld_ready, rf_wen, busy_mask[5]);
    end
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    #1;
    checks++;
    if (rf_wen !== 1'b0 || busy_mask !== '0 || err_stray_load !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: wen=%b busy=%h err=%b, expected 0/0/0", rf_wen, busy_mask, err_stray_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: ld_ready=%b wen=%b, expected 1/0", ld_ready, rf_wen);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom();
      alu_valid = 1'b1; alu_rd = AW'(8 + i); alu_data = d;
      exp_q.push_back({AW'(8 + i), d});
      @(negedge clk);
    end
    alu_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    fork
      monitor();
    join_none
    test_reset();
    test_alu_write();
    test_load_hazard();
    test_alu_load_collision();
    test_x0();
    test_stray_load();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
